// File: rtl/uart_flow_pkg.sv
// Shared constants for the UART flow-control block: XON/XOFF characters
// and the flow FSM state encoding.
package uart_flow_pkg;

  localparam logic [7:0] XON_CHAR  = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;

  typedef logic [1:0] flow_state_t;

  localparam flow_state_t XON_SENT  = 2'd0;
  localparam flow_state_t NEED_XOFF = 2'd1;
  localparam flow_state_t XOFF_SENT = 2'd2;
  localparam flow_state_t NEED_XON  = 2'd3;

  // Only meaningful in the two NEED_* states.
  function automatic logic [7:0] ctrl_char(input flow_state_t st);
    return (st == NEED_XOFF) ? XOFF_CHAR : XON_CHAR;
  endfunction

endpackage

// File: rtl/uart_flow_ctrl_byte_fifo.sv
// First-word-fall-through byte FIFO with explicit occupancy counter.
// A full FIFO refuses writes even if a pop happens in the same cycle.
module byte_fifo
  import uart_flow_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fill
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              push, pop;

  always_comb begin
    push     = in_valid & (fill_q != FULL_LVL) & ~reset;
    pop      = (fill_q != '0) & out_ready & ~reset;
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    fill_d   = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (pop && !push) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage carries no reset; validity is tracked by fill_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = push;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (fill_q != '0);
  assign fill      = fill_q;

endmodule

// File: rtl/uart_flow_ctrl.sv
// RX byte buffering with XON/XOFF generation from the fill level, and
// arbitration of the UART transmit register between control and keyboard bytes.
module uart_flow_ctrl
  import uart_flow_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int HIGH_MARK = 48,
  parameter int LOW_MARK  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [7:0]        kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_wait,
  input  logic              tx_tdre,
  output logic [ADDR_W:0]   fill,
  output logic              xoff_active
);

  localparam logic [ADDR_W:0] HIGH_LVL = (ADDR_W + 1)'(HIGH_MARK);
  localparam logic [ADDR_W:0] LOW_LVL  = (ADDR_W + 1)'(LOW_MARK);

  flow_state_t state_q, state_d;
  logic        holdoff_q, holdoff_d;
  logic        ctrl_pending, slot, ctrl_sent;
  logic        at_high, at_low;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (rx_data),
    .in_valid  (rx_valid),
    .in_ready  (rx_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill)
  );

  always_comb begin
    ctrl_pending = (state_q == NEED_XOFF) || (state_q == NEED_XON);
    slot         = tx_tdre & ~tx_wait & ~holdoff_q & ~reset;
    tx_we        = slot & (ctrl_pending | kbd_valid);
    kbd_ready    = slot & ~ctrl_pending & kbd_valid;
    tx_data      = '0;
    if (!reset) begin
      tx_data = ctrl_pending ? ctrl_char(state_q) : kbd_data;
    end
    ctrl_sent    = tx_we & ctrl_pending;
    holdoff_d    = tx_we;
    at_high      = (fill >= HIGH_LVL);
    at_low       = (fill <= LOW_LVL);
    xoff_active  = (state_q == XOFF_SENT) || (state_q == NEED_XON);

    // A request that has not yet been sent is withdrawn if the level swings back.
    state_d = state_q;
    case (state_q)
      XON_SENT:  if (at_high) state_d = NEED_XOFF;
      NEED_XOFF: begin
        if (ctrl_sent)   state_d = XOFF_SENT;
        else if (at_low) state_d = XON_SENT;
      end
      XOFF_SENT: if (at_low) state_d = NEED_XON;
      NEED_XON: begin
        if (ctrl_sent)    state_d = XON_SENT;
        else if (at_high) state_d = XOFF_SENT;
      end
      default:   state_d = XON_SENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= XON_SENT;
      holdoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
    end
  end

endmodule
